ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver with a scan-code FIFO, sitting upstream of the MIO bus as a read-only input peripheral next to buttons and switches. It samples the external PS/2 clock and data lines in the CPU clock domain and deframes 11-bit PS/2 frames. Valid scan-code bytes are buffered in a small FIFO. MIO_BUS pops bytes with a single-cycle read strobe and returns them to the CPU on Cpu_data4bus.

Parameters:
FIFO_DEPTH, 8, scan-code FIFO entries; power of 2, minimum 2.
TIMEOUT_CYC, 50000, clk cycles without a PS/2 falling edge before a partial frame is abandoned.
SYNC_STAGES, 2, flip-flop stages on ps2_clk and ps2_data; minimum 2.

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  reset, asynchronous, active-high.
ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
rd_en  input  1  pop strobe from MIO_BUS, one cycle per byte.
clr_err  input  1  clears the sticky overflow and frame_err flags.
data_out  output  8  FIFO head byte (first-word fall-through); 0 when empty.
valid  output  1  FIFO not empty.
count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow  output  1  sticky: a good frame was dropped because the FIFO was full.
frame_err  output  1  sticky: bad start bit, bad parity or bad stop bit seen.

Behaviour:
- Reset values: FSM IDLE, FIFO pointers 0, count 0, valid 0, data_out 0, overflow 0, frame_err 0, sync flops 1 (bus idle high).
- Input sync: ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge is the previous synced ps2_clk = 1 and the current = 0. Data is sampled from synced ps2_data in the same cycle as the edge.
- Frame format: start bit (0), 8 data bits LSB first, odd parity, stop bit (1).
- FSM states:
  - IDLE: on a falling edge, capture the start bit, go to DATA with bit index 0.
  - DATA: each falling edge shifts in one bit; after the 8th bit go to PARITY.
  - PARITY: on a falling edge capture the parity bit, go to STOP.
  - STOP: on a falling edge evaluate the frame, go to IDLE.
- Frame check: good when start = 0, XOR of the 8 data bits and the parity bit = 1, and stop = 1.
  - Good frame: push the byte into the FIFO in the cycle after the stop edge.
  - Bad frame: set frame_err; no push.
- Timeout: a counter resets on every falling edge and increments while the FSM is not IDLE. Reaching TIMEOUT_CYC-1 forces IDLE, discards the partial frame and sets frame_err.
- FIFO:
  - Push when full: byte dropped, overflow set.
  - Pop (rd_en) when empty: ignored.
  - Simultaneous push and pop: both take effect, count unchanged, including when full.
  - After a pop, data_out updates to the next entry in the following cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: clr_err clears both flags. If clr_err coincides with a new error event, the set wins.
- Latency: the pushed byte is visible on data_out/valid 2 clk cycles after the stop-bit falling edge reaches the synchronizer output.

Optional Feature:
PS2_BREAK_FILTER_EN
- Defined: byte 0xF0 is not pushed and sets a break_pending flag. The next good byte is also discarded and clears break_pending; only make codes reach the FIFO. A bad frame or timeout also clears break_pending.
- Undefined: every good byte, including 0xF0, is pushed raw; no break_pending logic exists.

Decomposition:
- Shared package ps2_pkg:
  - FSM state encoding (IDLE, DATA, PARITY, STOP).
  - FRAME_BITS = 11.
  - BREAK_CODE = 8'hF0.
  - Default TIMEOUT_CYC.
- One natural sub-module, ps2_fifo: synchronous FWFT FIFO with push, pop, full, empty and count, parameterized on depth and width 8.
- Deframer FSM and timeout counter stay in the top module.

Test Plan:
- Send 0x1C with correct odd parity (PS/2 clock half-period 40 clk) -> valid = 1, data_out = 8'h1C, count = 1; rd_en pulse -> valid = 0, data_out = 0.
- Send 0x1C with the parity bit inverted -> frame_err = 1, count = 0; clr_err pulse -> frame_err = 0.
- TIMEOUT_CYC = 200; send 5 bits then hold ps2_clk high for 300 cycles, then a full frame 0x32 -> frame_err = 1, data_out = 8'h32, count = 1.
- FIFO_DEPTH = 4; send 0x01..0x05 without reads -> count = 4, overflow = 1; pop order 0x01, 0x02, 0x03, 0x04.
- FIFO full; assert rd_en in the push cycle of a 5th byte 0x55 -> count stays 4, overflow = 0, last entry 0x55.
- Macro defined; send 0x1C, 0xF0, 0x1C, 0x32 -> FIFO holds 0x1C, 0x32 only. Macro undefined, same stimulus -> 0x1C, 0xF0, 0x1C, 0x32.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard receiver.
//   state_t         deframer FSM encoding (IDLE, DATA, PARITY, STOP)
//   FRAME_BITS      bits per PS/2 frame (start, 8 data, parity, stop)
//   BREAK_CODE      scan-code prefix that marks a key release
//   DEF_TIMEOUT_CYC default clk cycles before a stalled frame is abandoned
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   localparam int FRAME_BITS = 11;
   localparam logic [7:0] BREAK_CODE = 8'hF0;
   localparam int DEF_TIMEOUT_CYC = 50000;
endpackage

// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: MIO-side read port of the PS/2 receiver.
//   rd_en, clr_err           pop strobe and sticky-flag clear (driven by master)
//   data_out, valid, count   FWFT FIFO head byte, not-empty, occupancy
//   overflow, frame_err      sticky error flags
//   master: bus side; slave: receiver side.
interface ps2_kbd_rx_if #(parameter int FIFO_DEPTH = 8);
   logic rd_en;
   logic clr_err;
   logic [7:0] data_out;
   logic valid;
   logic [$clog2(FIFO_DEPTH):0] count;
   logic overflow;
   logic frame_err;
   modport master(output rd_en, clr_err, input data_out, valid, count, overflow, frame_err);
   modport slave(input rd_en, clr_err, output data_out, valid, count, overflow, frame_err);
endinterface

// File: rtl/ps2_fifo.sv
// ps2_fifo: first-word fall-through byte FIFO.
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write request and byte; accepted when not full or when popping
//   pop           read request; ignored when empty
//   dout          head byte, 0 when empty
//   full, empty   occupancy status
//   count         current occupancy
module ps2_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic wr, rd;
   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign rd    = pop & ~empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign wr    = push & (~full | rd);
   assign dout  = empty ? '0 : mem[rp];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (wr) wp <= wp + AW'(1);
         if (rd) rp <= rp + AW'(1);
         count <= count + (AW+1)'(wr) - (AW+1)'(rd);
      end
   always_ff @(posedge clk)
      if (wr) mem[wp] <= din;
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard deframer feeding a scan-code FIFO read by MIO_BUS.
//   clk, rst           system clock, asynchronous active-high reset
//   ps2_clk, ps2_data  raw PS/2 pins, asynchronous to clk
//   bus (slave)        rd_en/clr_err in; data_out/valid/count/overflow/frame_err out
// Build option PS2_BREAK_FILTER_EN: drop 0xF0 and the byte after it, so only
// make codes are queued.
module ps2_kbd_rx import ps2_pkg::*; #(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   ps2_kbd_rx_if.slave  bus
);
   localparam int TW = $clog2(TIMEOUT_CYC);
   logic [SYNC_STAGES-1:0] ck_sr, dt_sr;
   logic ck_s, dt_s, ck_prev, fall;
   state_t state, state_n;
   logic [2:0] idx;
   logic [7:0] sh, byte_q;
   logic start_b, par_b, push_q, full, empty;
   logic [TW-1:0] to_cnt;
   logic to_hit, frame_end, good, bad, accept;
   assign ck_s = ck_sr[SYNC_STAGES-1];
   assign dt_s = dt_sr[SYNC_STAGES-1];
   assign fall = ck_prev & ~ck_s;
   // a falling edge in the same cycle keeps the frame alive
   assign to_hit = (state != IDLE) & ~fall & (to_cnt == TW'(TIMEOUT_CYC - 1));
   assign frame_end = fall & (state == STOP);
   assign good = frame_end & ~start_b & (^{sh, par_b}) & dt_s;
   assign bad  = frame_end & ~good;
`ifdef PS2_BREAK_FILTER_EN
   logic brk;
   assign accept = good & ~brk & (sh != BREAK_CODE);
   always_ff @(posedge clk or posedge rst)
      if (rst) brk <= 1'b0;
      else if (bad | to_hit) brk <= 1'b0;
      else if (good) brk <= ~brk & (sh == BREAK_CODE);
`else
   assign accept = good;
`endif
   always_comb begin
      state_n = to_hit ? IDLE :
                !fall ? state :
                state == IDLE ? DATA :
                state == DATA ? (idx == 3'd7 ? PARITY : DATA) :
                state == PARITY ? STOP : IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ck_sr         <= '1;
         dt_sr         <= '1;
         ck_prev       <= 1'b1;
         idx           <= '0;
         sh            <= '0;
         start_b       <= 1'b0;
         par_b         <= 1'b0;
         to_cnt        <= '0;
         push_q        <= 1'b0;
         byte_q        <= '0;
         bus.overflow  <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         ck_sr   <= {ck_sr[SYNC_STAGES-2:0], ps2_clk};
         dt_sr   <= {dt_sr[SYNC_STAGES-2:0], ps2_data};
         ck_prev <= ck_s;
         to_cnt  <= (fall | to_hit | (state == IDLE)) ? '0 : to_cnt + TW'(1);
         if (fall && state == IDLE) begin
            start_b <= dt_s;
            idx     <= '0;
         end
         if (fall && state == DATA) begin
            sh  <= {dt_s, sh[7:1]};
            idx <= idx + 3'd1;
         end
         if (fall && state == PARITY) par_b <= dt_s;
         push_q <= accept;
         byte_q <= sh;
         // a new error event outranks a coincident clear
         bus.frame_err <= bad | to_hit | (bus.frame_err & ~bus.clr_err);
         bus.overflow  <= (push_q & full & ~bus.rd_en) | (bus.overflow & ~bus.clr_err);
      end
   ps2_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_q),
      .pop   (bus.rd_en),
      .din   (byte_q),
      .dout  (bus.data_out),
      .full  (full),
      .empty (empty),
      .count (bus.count)
   );
   assign bus.valid = ~empty;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed bench for ps2_kbd_rx with a byte scoreboard.
module tb_ps2_kbd_rx;
   import ps2_pkg::*;
   localparam int DEPTH = 4;
   localparam int HALF  = 40;
   logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   int n_chk = 0, n_fail = 0;
   logic [7:0] mq[$];
   bit brk_m = 0, ovf_m = 0, ferr_m = 0;
   ps2_kbd_rx_if #(.FIFO_DEPTH(DEPTH)) bus();
   ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(200), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus)
   );
   always #5 clk = ~clk;
   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic void model_good(logic [7:0] b);
`ifdef PS2_BREAK_FILTER_EN
      if (brk_m) begin
         brk_m = 0;
         return;
      end
      if (b == BREAK_CODE) begin
         brk_m = 1;
         return;
      end
`endif
      if (mq.size() < DEPTH) mq.push_back(b);
      else ovf_m = 1;
   endfunction
   task automatic send(logic [7:0] b, bit bad_par = 0, int nbits = FRAME_BITS, bit pop_push = 0);
      logic [FRAME_BITS-1:0] f;
      f = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
      if (pop_push) begin
         check("pp_head", bus.data_out, mq[0]);
         void'(mq.pop_front());
      end
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         tick(HALF);
         ps2_clk = 1'b0;
         if (pop_push && i == nbits - 1) begin
            tick(3);
            bus.rd_en = 1'b1;
            tick();
            bus.rd_en = 1'b0;
            tick(HALF - 4);
         end else tick(HALF);
         ps2_clk = 1'b1;
      end
      tick(HALF);
      if (nbits != FRAME_BITS || bad_par) begin
         ferr_m = 1;
         brk_m  = 0;
      end else model_good(b);
   endtask
   task automatic pop_chk(string tag);
      logic [7:0] exp;
      exp = mq.size() > 0 ? mq.pop_front() : 8'h00;
      check({tag, "_valid"}, bus.valid, 1);
      check(tag, bus.data_out, exp);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
   endtask
   task automatic flags_chk(string tag);
      check({tag, "_count"}, bus.count, mq.size());
      check({tag, "_ovf"}, bus.overflow, ovf_m);
      check({tag, "_ferr"}, bus.frame_err, ferr_m);
   endtask
   task automatic clr();
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      ovf_m  = 0;
      ferr_m = 0;
   endtask
   initial begin
      bus.rd_en   = 1'b0;
      bus.clr_err = 1'b0;
      tick(3);
      check("rst_valid", bus.valid, 0);
      check("rst_data", bus.data_out, 0);
      check("rst_count", bus.count, 0);
      check("rst_ovf", bus.overflow, 0);
      check("rst_ferr", bus.frame_err, 0);
      rst = 1'b0;
      tick(5);
      // single good byte, then pop back to empty
      send(8'h1C);
      check("one_valid", bus.valid, 1);
      check("one_data", bus.data_out, 8'h1C);
      check("one_count", bus.count, 1);
      pop_chk("one_pop");
      check("one_empty_valid", bus.valid, 0);
      check("one_empty_data", bus.data_out, 0);
      // bad parity, then clear
      send(8'h1C, 1);
      check("par_ferr", bus.frame_err, 1);
      check("par_count", bus.count, 0);
      clr();
      check("par_clr", bus.frame_err, 0);
      // stalled partial frame times out, then a good frame still lands
      send(8'hA5, 0, 5);
      tick(300);
      check("to_ferr", bus.frame_err, 1);
      check("to_count", bus.count, 0);
      send(8'h32);
      check("to_ferr_kept", bus.frame_err, 1);
      check("to_data", bus.data_out, 8'h32);
      check("to_count_after", bus.count, 1);
      pop_chk("to_pop");
      clr();
      // overfill a 4-deep FIFO
      for (int b = 1; b <= 5; b++) send(8'(b));
      check("ovf_count", bus.count, 4);
      check("ovf_flag", bus.overflow, 1);
      flags_chk("ovf");
      for (int k = 0; k < 4; k++) pop_chk("ovf_pop");
      check("ovf_drained", bus.valid, 0);
      clr();
      // full FIFO, pop in the push cycle of a fifth byte
      for (int b = 8'h11; b <= 8'h14; b++) send(8'(b));
      check("pp_full", bus.count, 4);
      send(8'h55, 0, FRAME_BITS, 1);
      check("pp_count", bus.count, 4);
      check("pp_ovf", bus.overflow, 0);
      flags_chk("pp");
      for (int k = 0; k < 4; k++) pop_chk("pp_pop");
      // break-code stream
      send(8'h1C);
      send(BREAK_CODE);
      send(8'h1C);
      send(8'h32);
`ifdef PS2_BREAK_FILTER_EN
      check("brk_count", bus.count, 2);
`else
      check("brk_count", bus.count, 4);
`endif
      flags_chk("brk");
      while (mq.size() > 0) pop_chk("brk_pop");
      check("brk_empty", bus.valid, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
